// File: rtl/division_repeated_subtraction_pkg.sv
// Shared constants and FSM state encoding for the repeated-subtraction divider.
package division_repeated_subtraction_pkg;

  localparam int DEFAULT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/division_repeated_subtraction_ctrl.sv
// Control FSM for the divider: accepts a request, sequences subtractions, pulses done.
module div_ctrl
  import division_repeated_subtraction_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divz,
  input  logic lt,
  output logic ld,
  output logic sub,
  output logic busy,
  output logic done
);

  state_t r_state;
  state_t w_next;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering in simulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: the default assignment up front keeps this block latch-free.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = divz ? DONE : SUB;
      SUB:     if (lt)    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A zero divisor goes straight to DONE, so busy is just "in SUB".
  always_comb begin
    ld   = (r_state == IDLE) && start;
    sub  = (r_state == SUB) && !lt;
    busy = (r_state == SUB);
    done = (r_state == DONE);
  end

endmodule

// File: rtl/division_repeated_subtraction.sv
// Unsigned divider by repeated subtraction: one subtract per clock, registered results.
module division_repeated_subtraction
  import division_repeated_subtraction_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dbz
);

  logic [W-1:0] r_rem;
  logic [W-1:0] r_den;
  logic [W-1:0] r_quo;
  logic         r_dbz;

  logic         w_ld;
  logic         w_sub;
  logic         w_divz;
  logic         w_lt;
  logic [W-1:0] w_diff;

  assign w_divz = (divisor == '0);
  assign w_lt   = (r_rem < r_den);
  assign w_diff = r_rem - r_den;

  div_ctrl u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .divz  (w_divz),
    .lt    (w_lt),
    .ld    (w_ld),
    .sub   (w_sub),
    .busy  (busy),
    .done  (done)
  );

  // Subtraction only fires while R>=D, so R never underflows and Q tops out at R's max.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_den <= '0;
      r_quo <= '0;
      r_dbz <= 1'b0;
    end else if (w_ld) begin
      r_rem <= dividend;
      r_den <= divisor;
      r_quo <= w_divz ? '1 : '0;
      r_dbz <= w_divz;
    end else if (w_sub) begin
      r_rem <= w_diff;
      r_quo <= r_quo + W'(1);
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_division_repeated_subtraction.sv
// Directed self-checking bench for division_repeated_subtraction.
module tb_division_repeated_subtraction;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        dbz;

  int checks = 0;
  int errors = 0;
  int edges;

  division_repeated_subtraction #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one accepting edge; edges=1 counts that edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
  endtask

  task automatic wait_done(input int limit);
    while (done !== 1'b1 && edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                              input logic d, input int exp_edges);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    check({tag, "_quotient"}, 32'(quotient), 32'(q));
    check({tag, "_remainder"}, 32'(remainder), 32'(r));
    check({tag, "_dbz"}, 32'(dbz), 32'(d));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_hold_quotient"}, 32'(quotient), 32'(q));
    check({tag, "_hold_remainder"}, 32'(remainder), 32'(r));
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_dbz", 32'(dbz), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 100/7 = 14 r 2, done 16 cycles after the start cycle
    start_op(16'd100, 16'd7);
    check("d100_7_busy_after_accept", 32'(busy), 32'd1);
    wait_done(100);
    check_result("d100_7", 16'd14, 16'd2, 1'b0, 16);

    start_op(16'd5, 16'd9);
    wait_done(100);
    check_result("d5_9", 16'd0, 16'd5, 1'b0, 2);

    start_op(16'd0, 16'd3);
    wait_done(100);
    check_result("d0_3", 16'd0, 16'd0, 1'b0, 2);

    start_op(16'hFFFF, 16'd1);
    wait_done(70000);
    check_result("dffff_1", 16'hFFFF, 16'd0, 1'b0, 65537);

    start_op(16'hFFFF, 16'hFFFF);
    wait_done(100);
    check_result("dffff_ffff", 16'd1, 16'd0, 1'b0, 3);

    // Divide by zero completes straight from the accepting edge
    start_op(16'd1234, 16'd0);
    wait_done(100);
    check_result("d1234_0", 16'hFFFF, 16'd1234, 1'b1, 1);

    start_op(16'd9, 16'd3);
    wait_done(100);
    check_result("d9_3", 16'd3, 16'd0, 1'b0, 5);

    // A second start and new operands mid-division must be ignored
    start_op(16'd1000, 16'd3);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      edges++;
    end
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd7;
    @(posedge clk);
    #1;
    edges++;
    start = 1'b0;
    wait_done(1000);
    check_result("d1000_3_restart_ignored", 16'd333, 16'd1, 1'b0, 335);
    check("d1000_3_no_second_op", 32'(busy), 32'd0);

    // Asynchronous reset mid-division aborts with no done pulse
    start_op(16'd1000, 16'd3);
    for (int i = 0; i < 49; i++) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dbz", 32'(dbz), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    start_op(16'd8, 16'd2);
    wait_done(100);
    check_result("d8_2_after_reset", 16'd4, 16'd0, 1'b0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/division_repeated_subtraction.md
DIVISION_REPEATED_SUBTRACTION -- requirements
Module: division_repeated_subtraction

Interface
REQ-001 SHALL have parameter W, default 16, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  W  numerator; sampled on the accepting edge only.
REQ-006 SHALL have port divisor  input  W  denominator; sampled on the accepting edge only.
REQ-007 SHALL have port busy  output  1  high from the accepting edge until DONE is entered.
REQ-008 SHALL have port done  output  1  single-cycle completion pulse.
REQ-009 SHALL have port quotient  output  W  result, registered.
REQ-010 SHALL have port remainder  output  W  result, registered.
REQ-011 SHALL have port dbz  output  1  divide-by-zero flag, registered.

Function
REQ-012 SHALL use FSM states IDLE, SUB and DONE; done SHALL equal (state==DONE).
REQ-013 In IDLE with start=1, the edge SHALL load R<=dividend, D<=divisor and Q<=0, clear dbz, and set busy.
REQ-014 On the same edge, the FSM SHALL go to SUB when divisor!=0, else to DONE.
REQ-015 When divisor==0, the edge SHALL also set Q<=all-ones, R<=dividend and dbz<=1.
REQ-016 In SUB with R>=D (unsigned W-bit compare), each edge SHALL perform R<=R-D and Q<=Q+1, and remain in SUB.
REQ-017 In SUB with R<D, the edge SHALL move to DONE and clear busy, with R and Q unchanged.
REQ-018 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-019 Latency: with N=floor(dividend/divisor), done SHALL be high during the cycle following edge k+N+1, where k is the accepting edge (N+2 cycles after start is sampled).
REQ-020 Latency: in the divide-by-zero case, done SHALL be high in the cycle after edge k.
REQ-021 quotient=Q and remainder=R SHALL drive the outputs directly; intermediate values are visible while busy.
REQ-022 Final values SHALL hold until the next accepting edge.
REQ-023 start SHALL be ignored in SUB and DONE; a start held high through DONE SHALL be accepted on the first IDLE edge.
REQ-024 Subtraction SHALL never underflow; Q SHALL never wrap (max N = 2^W-1 for divisor=1).
REQ-025 dividend=0 with divisor!=0 SHALL give quotient=0, remainder=0 and done 2 cycles after start.
REQ-026 Input changes while busy SHALL have no effect.

Reset
REQ-027 rst=1 SHALL asynchronously force state=IDLE, Q=0, R=0, D=0, dbz=0, busy=0 and done=0.
REQ-028 rst asserted mid-operation SHALL abort the division with no done pulse.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold the default width constant (16) and the state enum (IDLE, SUB, DONE).
REQ-031 The FSM SHALL be a separate sub-module div_ctrl (inputs start, divz, lt; outputs ld, sub, busy, done).
REQ-032 The datapath (R, D, Q registers, subtractor, comparator) SHALL reside in the top module.

Verification
REQ-033 rst, then 100/7 -> quotient=14, remainder=2, dbz=0, done 16 cycles after the start edge, one cycle wide.
REQ-034 5/9 -> quotient=0, remainder=5, done 2 cycles after start; then 0/3 -> quotient=0, remainder=0.
REQ-035 0xFFFF/1 -> quotient=0xFFFF, remainder=0 after 65537 cycles, with no wrap; 0xFFFF/0xFFFF -> quotient=1, remainder=0.
REQ-036 1234/0 -> dbz=1, quotient=0xFFFF, remainder=1234, done in the next cycle; a following 9/3 -> dbz=0, quotient=3, remainder=0.
REQ-037 Start 1000/3, pulse start again and change the operands at cycle 5 -> result stays 333 r 1, with a single done.
REQ-038 Start 1000/3, assert rst asynchronously at cycle 50 -> all outputs 0 immediately, no done; then 8/2 -> quotient=4, remainder=0.
